// File: rtl/seg_page_display.sv
// Paged, multiplexed 7-segment display for a bank of unsigned result values.
// Ports: clk, rst (async active-low), vals_in (packed values), mode (0 auto/1 manual),
//   page_next (manual advance pulse), page (current page), busy (converter running),
//   digit (one-hot position enable, [0] rightmost), out ({dp,g,f,e,d,c,b,a}).
module seg_page_display #(
    parameter int VAL_W       = 8,
    parameter int NUM_VALS    = 8,
    parameter int DIGITS      = 8,
    parameter int SCAN_DIV    = 50000,
    parameter int PAGE_FRAMES = 1000,
    parameter int ACTIVE_LOW  = 1,
    localparam int VPP        = DIGITS / 4,
    localparam int NPAGES     = NUM_VALS / VPP,
    localparam int PW         = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_VALS*VAL_W-1:0] vals_in,
    input  logic                      mode,
    input  logic                      page_next,
    output logic [PW-1:0]             page,
    output logic                      busy,
    output logic [DIGITS-1:0]         digit,
    output logic [7:0]                out
);

    localparam int   CW  = $clog2(SCAN_DIV);
    localparam int   FW  = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;
    localparam int   SW  = $clog2(DIGITS);
    localparam int   IW  = (VPP > 1) ? $clog2(VPP) : 1;
    localparam logic INV = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT
    } cv_state_e;

    function automatic logic [7:0] enc(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'h3F;
            4'h1: s = 8'h06;
            4'h2: s = 8'h5B;
            4'h3: s = 8'h4F;
            4'h4: s = 8'h66;
            4'h5: s = 8'h6D;
            4'h6: s = 8'h7D;
            4'h7: s = 8'h07;
            4'h8: s = 8'h7F;
            4'h9: s = 8'h6F;
            4'hA: s = 8'h77;
            4'hB: s = 8'h7C;
            4'hC: s = 8'h39;
            4'hD: s = 8'h5E;
            4'hE: s = 8'h79;
            4'hF: s = 8'h71;
        endcase
        return s;
    endfunction

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int n = 0; n < 3; n++) begin
            if (r[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      en_q, en_d;
    logic [SW-1:0]             pos_q, pos_d;
    logic [FW-1:0]             frm_q, frm_d;
    logic [PW-1:0]             page_q, page_d;
    logic                      pend_q;
    cv_state_e                 st_q, st_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [3:0]                bit_q, bit_d;
    logic [VAL_W-1:0]          bin_q, bin_d;
    logic [11:0]               bcd_q, bcd_d;
    logic [VPP*VAL_W-1:0]      snap_q, snap_d;
    logic [PW-1:0]             spage_q, spage_d;
    logic [VPP-1:0][11:0]      stage_q, stage_d;
    logic [VPP-1:0][11:0]      buf_q, buf_d;
    logic [PW-1:0]             bpage_q, bpage_d;
    logic                      bvalid_q, bvalid_d;
    logic [DIGITS-1:0]         digit_q, digit_d;
    logic [7:0]                out_q, out_d;

    logic                      tick, frame_end, page_chg, start;
    logic [11:0]               adj, shifted;
    logic [11:0]               v;
    logic [3:0]                hx;
    logic [7:0]                seg;

    // Scan timing and page control
    always_comb begin
        tick      = (cnt_q == CW'(SCAN_DIV - 1));
        cnt_d     = tick ? '0 : cnt_q + CW'(1);
        en_d      = en_q;
        pos_d     = pos_q;
        frame_end = tick && en_q && (pos_q == SW'(DIGITS - 1));
        if (tick) begin
            if (!en_q)          en_d  = 1'b1;
            else if (frame_end) pos_d = '0;
            else                pos_d = pos_q + SW'(1);
        end
        page_chg = mode ? page_next
                        : (frame_end && (frm_q == FW'(PAGE_FRAMES - 1)));
        if (mode || page_chg) frm_d = '0;
        else if (frame_end)   frm_d = frm_q + FW'(1);
        else                  frm_d = frm_q;
        page_d = page_q;
        if (page_chg) page_d = (page_q == PW'(NPAGES - 1)) ? '0 : page_q + PW'(1);
        // Page change always restarts; frame-end start only when idle.
        start = page_chg || pend_q || (frame_end && (st_q == S_IDLE));
    end

    // Converter next state
    always_comb begin
        st_d     = st_q;
        idx_d    = idx_q;
        bit_d    = bit_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        snap_d   = snap_q;
        spage_d  = spage_q;
        stage_d  = stage_q;
        buf_d    = buf_q;
        bpage_d  = bpage_q;
        bvalid_d = bvalid_q;
        adj      = add3(bcd_q);
        shifted  = (adj << 1) | 12'(bin_q[VAL_W-1]);
        unique case (st_q)
            S_IDLE: ;
            S_LOAD: begin
                for (int j = 0; j < VPP; j++) begin
                    if (idx_q == IW'(j)) bin_d = snap_q[j*VAL_W +: VAL_W];
                end
                bcd_d = '0;
                bit_d = '0;
                st_d  = S_SHIFT;
            end
            S_SHIFT: begin
                bcd_d = shifted;
                bin_d = bin_q << 1;
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'(VAL_W - 1)) begin
                    stage_d[idx_q] = shifted;
                    if (idx_q == IW'(VPP - 1)) begin
                        buf_d    = stage_d;
                        bpage_d  = spage_q;
                        bvalid_d = 1'b1;
                        st_d     = S_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                        st_d  = S_LOAD;
                    end
                end
            end
            default: st_d = S_IDLE;
        endcase
        // A restart discards any result finishing on the same edge.
        if (start) begin
            st_d     = S_LOAD;
            idx_d    = '0;
            spage_d  = page_d;
            buf_d    = buf_q;
            bpage_d  = bpage_q;
            bvalid_d = bvalid_q;
            for (int p = 0; p < NPAGES; p++) begin
                if (page_d == PW'(p)) snap_d = vals_in[p*VPP*VAL_W +: VPP*VAL_W];
            end
        end
    end

    // Segment pattern for the position shown next cycle
    always_comb begin
        v   = '0;
        hx  = '0;
        seg = '0;
        for (int s = 0; s < VPP; s++) begin
            if ((pos_d >> 2) == SW'(s)) begin
                v  = buf_q[VPP-1-s];
                hx = 4'(int'(bpage_q) * VPP + (VPP - 1 - s));
            end
        end
        case (pos_d[1:0])
            2'd3: seg = enc(hx) | 8'h80;
            2'd2: seg = (v[11:8] == 4'd0) ? 8'h00 : enc(v[11:8]);
            2'd1: seg = (v[11:4] == 8'd0) ? 8'h00 : enc(v[7:4]);
            2'd0: seg = enc(v[3:0]);
        endcase
        if (!bvalid_q || !en_d) seg = '0;
        digit_d = en_d ? (DIGITS'(1) << pos_d) : '0;
        if (INV) begin
            digit_d = ~digit_d;
            seg     = ~seg;
        end
        out_d = seg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            en_q     <= 1'b0;
            pos_q    <= '0;
            frm_q    <= '0;
            page_q   <= '0;
            pend_q   <= 1'b1;
            st_q     <= S_IDLE;
            idx_q    <= '0;
            bit_q    <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            snap_q   <= '0;
            spage_q  <= '0;
            stage_q  <= '0;
            buf_q    <= '0;
            bpage_q  <= '0;
            bvalid_q <= 1'b0;
            digit_q  <= {DIGITS{INV}};
            out_q    <= {8{INV}};
        end else begin
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            pos_q    <= pos_d;
            frm_q    <= frm_d;
            page_q   <= page_d;
            pend_q   <= 1'b0;
            st_q     <= st_d;
            idx_q    <= idx_d;
            bit_q    <= bit_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            snap_q   <= snap_d;
            spage_q  <= spage_d;
            stage_q  <= stage_d;
            buf_q    <= buf_d;
            bpage_q  <= bpage_d;
            bvalid_q <= bvalid_d;
            digit_q  <= digit_d;
            out_q    <= out_d;
        end
    end

    assign page  = page_q;
    assign busy  = (st_q != S_IDLE);
    assign digit = digit_q;
    assign out   = out_q;

endmodule

// File: tb/tb_seg_page_display.sv
// Directed bench for seg_page_display: reset state, auto paging,
// manual paging, per-page display tables, converter restart and async reset.
module tb_seg_page_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] vals_in;
    logic        mode;
    logic        page_next;
    logic [1:0]  page;
    logic        busy;
    logic [7:0]  digit;
    logic [7:0]  out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0]      pg;
        logic [7:0]      v0;
        logic [7:0][7:0] exp;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seg_page_display #(
        .VAL_W(8), .NUM_VALS(8), .DIGITS(8),
        .SCAN_DIV(2), .PAGE_FRAMES(2), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .vals_in(vals_in), .mode(mode),
        .page_next(page_next), .page(page), .busy(busy),
        .digit(digit), .out(out)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pulse();
        page_next = 1'b1;
        @(negedge clk);
        page_next = 1'b0;
    endtask

    // Capture one full frame starting at the next pos-0 enable.
    task automatic scan_frame(output logic [7:0][7:0] seg);
        int n;
        logic [7:0] oh;
        seg = '1;
        n = 0;
        while (digit == 8'hFE && n < 100) begin @(negedge clk); n++; end
        while (digit != 8'hFE && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL scan_sync: no frame start within 100 cycles");
        end
        for (int c = 0; c < 16; c++) begin
            for (int p = 0; p < 8; p++) begin
                oh = 8'd1 << p;
                if (digit == ~oh) seg[p] = out;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int t0;
        logic [1:0] prev;
        logic [7:0][7:0] seg;
        int ep[4];

        ep = '{1, 2, 3, 0};
        tbl[0] = '{2'd1, 8'd12, {8'h24, 8'hFF, 8'h92, 8'h82, 8'h30, 8'hFF, 8'hF8, 8'h80}};
        tbl[1] = '{2'd2, 8'd12, {8'h19, 8'hF9, 8'hC0, 8'hC0, 8'h12, 8'hFF, 8'hFF, 8'hF9}};
        tbl[2] = '{2'd3, 8'd12, {8'h02, 8'hFF, 8'hF9, 8'hB0, 8'h78, 8'hFF, 8'hFF, 8'h80}};
        tbl[3] = '{2'd0, 8'd12, {8'h40, 8'hFF, 8'hF9, 8'hA4, 8'h79, 8'hFF, 8'hB0, 8'h99}};
        tbl[4] = '{2'd0, 8'd255, {8'h40, 8'hA4, 8'h92, 8'h92, 8'h79, 8'hFF, 8'hB0, 8'h99}};

        rst       = 1'b0;
        mode      = 1'b0;
        page_next = 1'b0;
        vals_in   = {8'd8, 8'd13, 8'd1, 8'd100, 8'd78, 8'd56, 8'd34, 8'd12};
        repeat (3) @(negedge clk);
        chk("rst_digit", digit, 8'hFF);
        chk("rst_out", out, 8'hFF);
        chk("rst_page", page, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;

        // Auto rotation: 0 -> 1 -> 2 -> 3 -> 0, every 2 frames (32 cycles)
        prev = page;
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (page == prev && n < 200) begin @(negedge clk); n++; end
            chk($sformatf("auto_page%0d", k), page, ep[k]);
            if (k > 0) chk($sformatf("auto_interval%0d", k), cyc - t0, 32);
            t0 = cyc;
            prev = page;
            if (k == 0) begin
                pulse();
                chk("auto_ignores_next", page, 1);
            end
        end

        // Page 2 left slot in auto mode: "4." "1" "0" "0"
        n = 0;
        while (page != 2'd2 && n < 200) begin @(negedge clk); n++; end
        chk("auto_reach_p2", page, 2);
        scan_frame(seg);
        for (int p = 4; p < 8; p++)
            chk($sformatf("auto_p2_pos%0d", p), seg[p], tbl[1].exp[p]);

        // Manual mode: table of page displays
        mode = 1'b1;
        for (int r = 0; r < 5; r++) begin
            vals_in[7:0] = tbl[r].v0;
            for (int k = 0; k < 4 && page != tbl[r].pg; k++) pulse();
            chk($sformatf("row%0d_page", r), page, tbl[r].pg);
            repeat (40) @(negedge clk);
            scan_frame(seg);
            for (int p = 0; p < 8; p++)
                chk($sformatf("row%0d_pos%0d", r, p), seg[p], tbl[r].exp[p]);
        end

        // Manual advance timing and hold
        pulse();
        chk("man_next_page", page, 1);
        chk("man_next_busy", busy, 1);
        repeat (160) @(negedge clk);
        chk("man_hold_page", page, 1);

        // Pulse while busy restarts the full conversion
        pulse();
        repeat (5) @(negedge clk);
        chk("restart_busy_mid", busy, 1);
        pulse();
        chk("restart_page", page, 3);
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        chk("restart_busy_len", n, 18);

        // Async reset in the middle of a conversion
        pulse();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_digit", digit, 8'hFF);
        chk("arst_out", out, 8'hFF);
        chk("arst_page", page, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
